// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory arbiter: FSM state encoding and the IF/DM grant encoding.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StBusyIf = 2'd1,
      StBusyDm = 2'd2,
      StResp   = 2'd3
   } arb_state_e;

   typedef enum logic {
      GntIf = 1'b0,
      GntDm = 1'b1
   } grant_e;

   // Streak counter width able to hold 0..limit inclusive.
   function automatic int unsigned streak_width(input int unsigned limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port memory.
// Data wins by default; a streak counter bounds how long a waiting fetch can be passed over.
module mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,

   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,

   output logic              stall_o
);

   localparam int unsigned StreakW = streak_width(STARVE_LIMIT);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

   arb_state_e          state_q;
   logic [StreakW-1:0]  streak_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                if_ack_q;
   logic                dm_ack_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   dm_rdata_q;

   logic                starved;
   logic                grant_valid;
   grant_e              grant;
   logic [StreakW-1:0]  streak_dm;

   assign starved = (streak_q == StreakMax);

   always_comb begin
      grant_valid = 1'b0;
      grant       = GntDm;
      if (dm_req_i && !(if_req_i && starved)) begin
         grant_valid = 1'b1;
         grant       = GntDm;
      end else if (if_req_i) begin
         grant_valid = 1'b1;
         grant       = GntIf;
      end
   end

   // Streak value after a DM grant: counts only while a fetch is actually waiting.
   always_comb begin
      streak_dm = '0;
      if (if_req_i) begin
         streak_dm = starved ? streak_q : streak_q + StreakW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= StIdle;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_valid) begin
                  mem_req_q <= 1'b1;
                  if (grant == GntDm) begin
                     mem_we_q    <= dm_we_i;
                     mem_addr_q  <= dm_addr_i;
                     mem_wdata_q <= dm_wdata_i;
                     streak_q    <= streak_dm;
                     state_q     <= StBusyDm;
                  end else begin
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr_i;
                     mem_wdata_q <= '0;
                     streak_q    <= '0;
                     state_q     <= StBusyIf;
                  end
               end
            end
            StBusyIf: begin
               if (mem_ack_i) begin
                  mem_req_q  <= 1'b0;
                  if_rdata_q <= mem_rdata_i;
                  if_ack_q   <= 1'b1;
                  state_q    <= StResp;
               end
            end
            StBusyDm: begin
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  // Stores leave the last load data visible.
                  if (!mem_we_q) begin
                     dm_rdata_q <= mem_rdata_i;
                  end
                  dm_ack_q  <= 1'b1;
                  state_q   <= StResp;
               end
            end
            StResp: begin
               if_ack_q <= 1'b0;
               dm_ack_q <= 1'b0;
               state_q  <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_ack_o    = if_ack_q;
   assign dm_ack_o    = dm_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;

   // Gated by reset so every output reads 0 while reset is held.
   assign stall_o = rst_i & ((if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: latency, priority, starvation limit,
// write wait states and mid-transaction reset.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              clk_i;
   logic              rst_i;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_ack_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic              dm_ack_o;
   logic [DATA_W-1:0] dm_rdata_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              stall_o;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (4)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_ack_o    (if_ack_o),
      .if_rdata_o  (if_rdata_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_ack_o    (dm_ack_o),
      .dm_rdata_o  (dm_rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .stall_o     (stall_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [ADDR_W-1:0] exp_addr;
      rst_i      = 1'b1;
      if_req_i   = 1'b0;
      if_addr_i  = '0;
      dm_req_i   = 1'b0;
      dm_we_i    = 1'b0;
      dm_addr_i  = '0;
      dm_wdata_i = '0;
      mem_ack_i  = 1'b0;
      mem_rdata_i = '0;

      // Reset state
      #1 rst_i = 1'b0;
      #1;
      check("rst_mem_req", mem_req_o, 0);
      check("rst_if_ack", if_ack_o, 0);
      check("rst_dm_ack", dm_ack_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_stall", stall_o, 0);
      tick();
      tick();
      rst_i = 1'b1;

      // Single fetch, zero-wait memory
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0010;
      #1;
      check("if1_stall_pending", stall_o, 1);
      tick();
      check("if1_busy_req", mem_req_o, 1);
      check("if1_busy_addr", mem_addr_o, 32'h0000_0010);
      check("if1_busy_we", mem_we_o, 0);
      check("if1_busy_ack", if_ack_o, 0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0000_0013;
      tick();
      check("if1_resp_ack", if_ack_o, 1);
      check("if1_resp_rdata", if_rdata_o, 32'h0000_0013);
      check("if1_resp_dm_ack", dm_ack_o, 0);
      check("if1_resp_mem_req", mem_req_o, 0);
      check("if1_resp_stall", stall_o, 0);
      if_req_i  = 1'b0;
      mem_ack_i = 1'b0;
      tick();
      check("if1_idle_ack", if_ack_o, 0);
      check("if1_idle_rdata_hold", if_rdata_o, 32'h0000_0013);

      // Simultaneous IF and DM: DM first, then IF
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0040;
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h0000_0100;
      tick();
      check("both_first_addr", mem_addr_o, 32'h0000_0100);
      check("both_first_stall", stall_o, 1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hCAFE_0001;
      tick();
      check("both_dm_ack", dm_ack_o, 1);
      check("both_dm_rdata", dm_rdata_o, 32'hCAFE_0001);
      check("both_if_ack_low", if_ack_o, 0);
      check("both_stall_if_wait", stall_o, 1);
      dm_req_i  = 1'b0;
      mem_ack_i = 1'b0;
      tick();
      check("both_idle_mem_req", mem_req_o, 0);
      tick();
      check("both_second_addr", mem_addr_o, 32'h0000_0040);
      check("both_second_we", mem_we_o, 0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h1111_2222;
      tick();
      check("both_if_ack", if_ack_o, 1);
      check("both_if_rdata", if_rdata_o, 32'h1111_2222);
      check("both_dm_rdata_hold", dm_rdata_o, 32'hCAFE_0001);
      if_req_i  = 1'b0;
      mem_ack_i = 1'b0;
      tick();

      // Starvation limit: four DM grants, then IF
      if_req_i    = 1'b1;
      if_addr_i   = 32'h0000_0080;
      dm_req_i    = 1'b1;
      dm_we_i     = 1'b0;
      dm_addr_i   = 32'h0000_0300;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h3333_0000;
      for (int i = 0; i < 5; i++) begin
         exp_addr = (i < 4) ? 32'h0000_0300 : 32'h0000_0080;
         tick();
         check($sformatf("starve_grant%0d_addr", i), mem_addr_o, exp_addr);
         tick();
         check($sformatf("starve_grant%0d_dm_ack", i), dm_ack_o, (i < 4) ? 1 : 0);
         check($sformatf("starve_grant%0d_if_ack", i), if_ack_o, (i < 4) ? 0 : 1);
         if (i == 4) begin
            if_req_i  = 1'b0;
            dm_req_i  = 1'b0;
            mem_ack_i = 1'b0;
         end
         tick();
      end

      // DM write with three wait states; requester drops req mid-transaction
      dm_req_i    = 1'b1;
      dm_we_i     = 1'b1;
      dm_addr_i   = 32'h0000_0200;
      dm_wdata_i  = 32'hDEAD_BEEF;
      mem_rdata_i = 32'h5555_AAAA;
      tick();
      dm_req_i   = 1'b0;
      dm_addr_i  = 32'h0000_0999;
      dm_wdata_i = 32'h0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("wr_cyc%0d_req", k), mem_req_o, 1);
         check($sformatf("wr_cyc%0d_we", k), mem_we_o, 1);
         check($sformatf("wr_cyc%0d_addr", k), mem_addr_o, 32'h0000_0200);
         check($sformatf("wr_cyc%0d_wdata", k), mem_wdata_o, 32'hDEAD_BEEF);
         check($sformatf("wr_cyc%0d_ack", k), dm_ack_o, 0);
         if (k == 3) mem_ack_i = 1'b1;
         tick();
      end
      mem_ack_i = 1'b0;
      check("wr_resp_ack", dm_ack_o, 1);
      check("wr_resp_rdata_unchanged", dm_rdata_o, 32'h3333_0000);
      check("wr_resp_mem_req", mem_req_o, 0);
      tick();
      check("wr_idle_ack", dm_ack_o, 0);

      // Reset during BUSY_DM, stray mem_ack in IDLE
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h0000_0400;
      tick();
      check("rst2_busy_req", mem_req_o, 1);
      dm_req_i = 1'b0;
      #2 rst_i = 1'b0;
      #1;
      check("rst2_mem_req_now", mem_req_o, 0);
      check("rst2_dm_ack", dm_ack_o, 0);
      check("rst2_dm_rdata", dm_rdata_o, 0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h7777_7777;
      tick();
      rst_i = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check($sformatf("rst2_post%0d_dm_ack", j), dm_ack_o, 0);
         check($sformatf("rst2_post%0d_mem_req", j), mem_req_o, 0);
         check($sformatf("rst2_post%0d_rdata", j), dm_rdata_o, 0);
      end
      mem_ack_i = 1'b0;

      // First grant after release only on a rising edge with rst_i high
      rst_i    = 1'b0;
      dm_req_i = 1'b1;
      tick();
      rst_i = 1'b1;
      #1;
      check("rel_no_early_grant", mem_req_o, 0);
      tick();
      check("rel_grant_on_edge", mem_req_o, 1);
      check("rel_grant_addr", mem_addr_o, 32'h0000_0400);
      dm_req_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: request address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch waits.
REQ-004 SHALL have port clk_i  in  1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_i  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req_i in 1, if_addr_i in ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports if_ack_o out 1, if_rdata_o out DATA_W: fetch completion pulse and instruction.
REQ-008 SHALL have ports dm_req_i in 1, dm_we_i in 1, dm_addr_i in ADDR_W, dm_wdata_i in DATA_W: MEM-stage request, write enable, address and write data.
REQ-009 SHALL have ports dm_ack_o out 1, dm_rdata_o out DATA_W: data completion pulse and load data.
REQ-010 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out ADDR_W, mem_wdata_o out DATA_W: shared single-port memory request.
REQ-011 SHALL have ports mem_ack_i in 1, mem_rdata_i in DATA_W: memory completion and read data.
REQ-012 SHALL have port stall_o  out  1: pipeline stall while any request is outstanding.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-014 In IDLE, SHALL grant on a cycle with a request: dm_req_i wins over if_req_i, except per REQ-020; go to BUSY_DM or BUSY_IF.
REQ-015 On grant, SHALL register the granted address, we and wdata into mem_*_o; mem_we_o = 0 for fetches.
REQ-016 In BUSY_*, SHALL hold mem_req_o = 1 and all mem_*_o stable until mem_ack_i = 1; then capture mem_rdata_i and go to RESP.
REQ-017 In RESP, SHALL assert exactly one of if_ack_o/dm_ack_o for one cycle, then return to IDLE.
REQ-018 SHALL present captured read data on if_rdata_o/dm_rdata_o with the ack and hold it until the next capture for that port; a DM write leaves dm_rdata_o unchanged.
REQ-019 Minimum latency: request sampled in IDLE at cycle N, zero-wait mem_ack_i at N+1, ack at N+2, IDLE at N+3.
REQ-020 SHALL keep a streak counter: increments on a DM grant while if_req_i = 1, clears on an IF grant or on a DM grant with if_req_i = 0, saturates at STARVE_LIMIT; with both requesting and streak = STARVE_LIMIT, IF wins.
REQ-021 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
REQ-022 Requesters hold req and fields stable until ack; req still high in the cycle after ack is a new request.
REQ-023 Requester dropping req during BUSY_*: transaction SHALL complete and still pulse ack.
REQ-024 mem_ack_i in IDLE or RESP SHALL be ignored.
REQ-025 Simultaneous new requests during BUSY/RESP SHALL wait; arbitration occurs only in IDLE.

Reset
REQ-026 On rst_i = 0, SHALL immediately force IDLE, clear the streak counter and drive all outputs to 0, including mem_req_o and both acks.
REQ-027 Reset mid-transaction SHALL abandon it: no ack is issued after reset release.
REQ-028 First grant after reset release SHALL occur no earlier than the first rising edge with rst_i = 1.

Structure
REQ-029 State enum and the IF/DM grant encoding SHALL live in shared package cpu_mem_pkg.
REQ-030 No sub-module: FSM, streak counter and capture registers are inline.

Verification
REQ-031 Single IF read 0x0000_0010, mem_ack_i at first BUSY cycle, rdata 0x0000_0013 -> if_ack_o at cycle N+2 with if_rdata_o = 0x0000_0013.
REQ-032 IF and DM request same cycle, DM load 0x100 -> DM granted first; IF granted in next IDLE; stall_o high until each ack.
REQ-033 if_req_i held high, dm_req_i continuously high, STARVE_LIMIT = 4 -> grant order DM, DM, DM, DM, IF.
REQ-034 DM write 0x200 data 0xDEAD_BEEF, mem_ack_i after 3 wait cycles -> mem_we_o = 1 and fields stable for 4 cycles; dm_ack_o one cycle; dm_rdata_o unchanged.
REQ-035 rst_i low during BUSY_DM -> mem_req_o = 0 same cycle; no dm_ack_o after release; stray mem_ack_i in IDLE ignored.
